shift_left_iterative: RTL and testbench
=======================================

# shift_left_iterative

Multi-cycle logical left shifter, the left-direction counterpart of the combinational right-arithmetic shifter in the Phase 1 datapath. It accepts an operand and a shift amount on a start pulse and shifts one bit position per clock. It signals completion with a one-cycle done pulse and holds the result until the next accepted start. It also reports the last bit shifted out, for flag generation.

## Interface
- WIDTH, 32, operand/result width in bits; power of two, ≥ 2.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces IDLE and zeroes all outputs.
- start  in  1  request; sampled only in IDLE.
- data_in  in  WIDTH  operand; captured on the accepting edge.
- shift_amount  in  32  unsigned shift count; captured on the accepting edge.
- data_out  out  WIDTH  shifted result; reset 0.
- carry_out  out  1  last bit shifted out of the MSB; reset 0.
- busy  out  1  high while in SHIFT; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: shifting one bit per clock.
  - DONE: one-cycle completion state.
- Count rule: N = min(shift_amount, WIDTH). Amounts ≥ WIDTH saturate to WIDTH, which yields result 0.
- Internal counter is clog2(WIDTH)+1 bits wide.
- IDLE, start=1 at an edge (the accept edge):
  - work register ← data_in.
  - count ← N.
  - carry_out ← 0.
  - next state is SHIFT if N>0, else DONE.
- SHIFT, each edge:
  - carry_out ← work[WIDTH-1].
  - work ← work << 1, with zero fill.
  - count ← count−1.
  - when count reaches 0, next state is DONE.
- DONE: done=1 for one cycle, then unconditional return to IDLE.
- data_out: drives the work register continuously. It is valid when done=1 and stays stable in IDLE until the next accept edge.
- start is ignored in SHIFT and DONE; no queuing.
- Reset asserted in any state, including mid-shift: immediately IDLE, all outputs 0, count 0. The in-flight operation is discarded; no done pulse.

## Timing
- With accept edge = edge 0, done is high in the cycle following edge max(N,0). N=0 means done follows edge 0; N=k means done follows edge k.
- busy is high in the cycles after edges 0..N−1 (N cycles total). busy is never high together with done.
- Back-to-back: start held high continuously is re-accepted at the edge that finds the block in IDLE, i.e. the edge after the done cycle. Minimum issue interval is N+2 cycles.
- Worst-case latency: WIDTH cycles from the accept edge to done.

## Test plan
- Basic shift: data_in=5, shift_amount=3, start pulse → busy for 3 cycles, done after edge 3, data_out=40 (0x00000028), carry_out=0.
- Carry-out:
  - data_in=0x80000001, shift_amount=1 → done after edge 1, data_out=0x00000002, carry_out=1.
  - data_in=−6 (0xFFFFFFFA), shift_amount=1 → data_out=0xFFFFFFF4, carry_out=1.
- Zero and saturated amounts:
  - shift_amount=0, data_in=0x12345678 → busy never rises, done after edge 0, data_out=0x12345678, carry_out=0.
  - shift_amount=40, data_in=0x00000001 → 32 busy cycles, data_out=0, carry_out=1.
- start during busy: raise start again while shifting 5<<3 → ignored, result 40 unchanged, a single done pulse. With start then held high, the next accept occurs at the edge after done.
- Reset mid-operation: assert reset at cycle 2 of a 0xFFFFFFFF<<10 operation → data_out=0, carry_out=0, busy=0, done=0 immediately (asynchronously). After reset release, a new start (6<<1) completes normally with data_out=12.
- Result hold: after 5<<3 completes, leave start low for 10 cycles while changing data_in and shift_amount → data_out stays 40, done stays 0.

Source files
------------

// File: rtl/shift_left_iterative.sv
// Multi-cycle logical left shifter: one bit position per clock, done pulse on completion,
// result held until the next accepted start, last shifted-out bit reported on carry_out.
module shift_left_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [31:0]      shift_amount,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] SAT_COUNT = CW'(WIDTH);
    localparam logic [31:0]   WIDTH_32  = 32'(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    count;
    logic [CW-1:0]    start_count;

    // Amounts of WIDTH or more saturate; shifting WIDTH times already clears the word.
    always_comb begin
        start_count = shift_amount[CW-1:0];
        if (shift_amount >= WIDTH_32) begin
            start_count = SAT_COUNT;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            work      <= '0;
            count     <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work      <= data_in;
                        count     <= start_count;
                        carry_out <= 1'b0;
                        state     <= (start_count != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    carry_out <= work[WIDTH-1];
                    work      <= {work[WIDTH-2:0], 1'b0};
                    count     <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign data_out = work;
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_shift_left_iterative.sv
// Scoreboard bench for shift_left_iterative: expected results are queued when an operation
// is issued and compared when the DUT raises done.
module tb_shift_left_iterative;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             carry;
        int               n;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [31:0]      shift_amount = '0;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;
    logic             busy;
    logic             done;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_count = 0;
    int   done_count = 0;
    logic prev_done = 1'b0;

    shift_left_iterative #(.WIDTH(WIDTH)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .data_in(data_in),
        .shift_amount(shift_amount),
        .data_out(data_out),
        .carry_out(carry_out),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [31:0] amt);
        exp_t e;
        e.n = (amt >= 32'(WIDTH)) ? WIDTH : int'(amt);
        e.data = (e.n >= WIDTH) ? '0 : (d << e.n);
        e.carry = (e.n == 0) ? 1'b0 : d[WIDTH - e.n];
        return e;
    endfunction

    task automatic apply_stimulus(input logic [WIDTH-1:0] d, input logic [31:0] amt);
        @(negedge clock);
        data_in = d;
        shift_amount = amt;
        start = 1'b1;
        sb.push_back(model(d, amt));
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        if (sb.size() != 0) begin
            check_output("timeout_pending", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // Monitor: pops one expectation per done pulse and checks result, carry and busy length.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            busy_count = 0;
        end else begin
            if (busy) busy_count++;
            if (done) begin
                done_count++;
                check_output("busy_with_done", 64'(busy), 64'd0);
                check_output("done_width", 64'(prev_done), 64'd0);
                check_output("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_output("data_out", 64'(data_out), 64'(e.data));
                    check_output("carry_out", 64'(carry_out), 64'(e.carry));
                    check_output("busy_cycles", 64'(busy_count), 64'(e.n));
                end
                busy_count = 0;
            end
        end
        prev_done = done;
    end

    initial begin
        int d0;
        int cyc;

        #2;
        check_output("rst_data_out", 64'(data_out), 64'd0);
        check_output("rst_carry_out", 64'(carry_out), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        apply_stimulus(32'd5, 32'd3);
        wait_idle();
        apply_stimulus(32'h8000_0001, 32'd1);
        wait_idle();
        apply_stimulus(32'hFFFF_FFFA, 32'd1);
        wait_idle();
        apply_stimulus(32'h1234_5678, 32'd0);
        wait_idle();
        apply_stimulus(32'h0000_0001, 32'd40);
        wait_idle();
        apply_stimulus(32'hA5A5_F00F, 32'd32);
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus($urandom, $urandom_range(0, 35));
            wait_idle();
        end

        // start raised while shifting must be ignored
        d0 = done_count;
        apply_stimulus(32'd5, 32'd3);
        @(negedge clock);
        start = 1'b1;
        data_in = 32'd99;
        shift_amount = 32'd2;
        @(negedge clock);
        start = 1'b0;
        wait_idle();
        @(negedge clock);
        @(negedge clock);
        check_output("single_done", 64'(done_count - d0), 64'd1);

        // start held high: re-accepted on the edge after the done cycle
        apply_stimulus(32'd5, 32'd3);
        @(negedge clock);
        start = 1'b1;
        data_in = 32'd6;
        shift_amount = 32'd1;
        sb.push_back(model(32'd6, 32'd1));
        cyc = 0;
        while (done !== 1'b1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check_output("held_first_done", 64'(done), 64'd1);
        @(negedge clock);
        check_output("held_idle_busy", 64'(busy), 64'd0);
        check_output("held_idle_done", 64'(done), 64'd0);
        @(negedge clock);
        check_output("held_reaccept_busy", 64'(busy), 64'd1);
        start = 1'b0;
        wait_idle();

        // result hold while inputs wander
        apply_stimulus(32'd5, 32'd3);
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            data_in = $urandom;
            shift_amount = $urandom;
            check_output("hold_data_out", 64'(data_out), 64'd40);
            check_output("hold_done", 64'(done), 64'd0);
        end

        // asynchronous reset in the middle of a shift
        apply_stimulus(32'hFFFF_FFFF, 32'd10);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_output("midrst_data_out", 64'(data_out), 64'd0);
        check_output("midrst_carry_out", 64'(carry_out), 64'd0);
        check_output("midrst_busy", 64'(busy), 64'd0);
        check_output("midrst_done", 64'(done), 64'd0);
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_output("post_rst_done", 64'(done), 64'd0);
            check_output("post_rst_busy", 64'(busy), 64'd0);
        end
        apply_stimulus(32'd6, 32'd1);
        wait_idle();
        @(negedge clock);
        check_output("final_data_out", 64'(data_out), 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
